// File: rtl/sorted_frame_tx.sv
// Captures one sorted 8-word frame from the merge sorter and streams it out
// lowest index first over valid/ready, flagging frames that are not non-decreasing.
module sorted_frame_tx #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] y3,
  input  logic [W-1:0] y4,
  input  logic [W-1:0] y5,
  input  logic [W-1:0] y6,
  input  logic [W-1:0] y7,
  input  logic [W-1:0] y8,
  output logic         load_ready,
  output logic [W-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic [2:0]   tx_idx,
  output logic         order_err,
  output logic [7:0]   frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_reg, state_next;
  logic [2:0]   idx_reg, idx_next;
  logic [W-1:0] frame_reg [8];
  logic [W-1:0] y_in [8];
  logic [W-1:0] tx_data_reg;
  logic         order_err_reg;
  logic [7:0]   frame_cnt_reg;
  logic [6:0]   gt;
  logic         load_acc;
  logic         xfer;

  assign y_in[0] = y1;
  assign y_in[1] = y2;
  assign y_in[2] = y3;
  assign y_in[3] = y4;
  assign y_in[4] = y5;
  assign y_in[5] = y6;
  assign y_in[6] = y7;
  assign y_in[7] = y8;

  // One unsigned compare per adjacent pair; equal neighbours are legal.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_order
      assign gt[gi] = y_in[gi] > y_in[gi+1];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_acc   = 1'b0;
    xfer       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          load_acc   = 1'b1;
          idx_next   = 3'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          xfer = 1'b1;
          if (idx_reg == 3'd7) state_next = IDLE;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      tx_data_reg   <= '0;
      order_err_reg <= 1'b0;
      frame_cnt_reg <= 8'd0;
      for (int i = 0; i < 8; i++) frame_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load_acc) begin
        for (int i = 0; i < 8; i++) frame_reg[i] <= y_in[i];
        order_err_reg <= |gt;
        tx_data_reg   <= y_in[0];
      end
      // tx_data is registered, so preload the next word on each non-final transfer.
      if (xfer && idx_reg != 3'd7) tx_data_reg <= frame_reg[idx_reg + 3'd1];
      if (xfer && idx_reg == 3'd7) frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign load_ready = (state_reg == IDLE);
  assign tx_valid   = (state_reg == SEND);
  assign tx_last    = (state_reg == SEND) && (idx_reg == 3'd7);
  assign tx_idx     = idx_reg;
  assign tx_data    = tx_data_reg;
  assign order_err  = order_err_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_sorted_frame_tx.sv
// Scoreboard bench for sorted_frame_tx: stimulus pushes expected words,
// a negedge monitor pops and compares every transfer.
module tb_sorted_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] y1 = '0, y2 = '0, y3 = '0, y4 = '0, y5 = '0, y6 = '0, y7 = '0, y8 = '0;
  logic       load_ready, tx_valid, tx_last, order_err;
  logic       tx_ready = 1'b1;
  logic [5:0] tx_data;
  logic [2:0] tx_idx;
  logic [7:0] frame_cnt;

  sorted_frame_tx #(.W(6)) dut (
    .clk(clk), .rst(rst), .load(load),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7), .y8(y8),
    .load_ready(load_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .tx_idx(tx_idx),
    .order_err(order_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] d;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         npass = 0;
  int         ntotal = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       bp_en = 1'b0;
  logic [5:0] bp_pat = 6'b101001;  // bit k = tx_ready in cycle k: 1,0,0,1,0,1

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    ntotal++;
    $display("FAIL %s", name);
  endtask

  // Backpressure pattern driver
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        tx_ready = bp_pat[k % 6];
        k++;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor
  logic stalled = 1'b0, last_done = 1'b0, mid = 1'b0;
  exp_t hold, e;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0; last_done = 1'b0; mid = 1'b0;
    end else begin
      if (last_done) chk("idle_after_last", {30'd0, load_ready, tx_valid}, 32'd2);
      if (mid) chk("no_bubble", {31'd0, tx_valid}, 32'd1);
      last_done = 1'b0; mid = 1'b0;
      if (tx_valid) begin
        if (stalled) begin
          chk("stall_data", {26'd0, tx_data}, {26'd0, hold.d});
          chk("stall_idx", {29'd0, tx_idx}, {29'd0, hold.idx});
        end
        if (tx_ready) begin
          stalled = 1'b0;
          if (sb.size() == 0) fail_now("unexpected_word");
          else begin
            e = sb.pop_front();
            chk("tx_data", {26'd0, tx_data}, {26'd0, e.d});
            chk("tx_idx", {29'd0, tx_idx}, {29'd0, e.idx});
            chk("tx_last", {31'd0, tx_last}, {31'd0, e.last});
            $display("xfer idx=%0d data=%0d last=%0d", tx_idx, tx_data, tx_last);
            last_done = e.last;
            mid = !e.last;
          end
        end else begin
          stalled = 1'b1;
          hold = '{d: tx_data, idx: tx_idx, last: tx_last};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  function automatic logic [7:0][5:0] mk(input logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8);
    mk = {a8, a7, a6, a5, a4, a3, a2, a1};
  endfunction

  task automatic set_y(input logic [7:0][5:0] f);
    y1 = f[0]; y2 = f[1]; y3 = f[2]; y4 = f[3];
    y5 = f[4]; y6 = f[5]; y7 = f[6]; y8 = f[7];
  endtask

  task automatic push_frame(input logic [7:0][5:0] f);
    for (int i = 0; i < 8; i++) sb.push_back('{d: f[i], idx: i[2:0], last: (i == 7)});
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!load_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!load_ready) fail_now("timeout_wait_idle");
  endtask

  // Loads a frame (caller is at posedge+1); returns at posedge+1 after the load edge.
  task automatic start_frame(input logic [7:0][5:0] f, input logic exp_err, input logic scramble);
    wait_idle();
    set_y(f);
    load = 1'b1;
    push_frame(f);
    @(posedge clk); #1;
    load = 1'b0;
    chk("order_err_at_load", {31'd0, order_err}, {31'd0, exp_err});
    chk("valid_after_load", {31'd0, tx_valid}, 32'd1);
    if (scramble) begin
      set_y(mk(6'd9, 6'd3, 6'd60, 6'd0, 6'd33, 6'd17, 6'd2, 6'd11));
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      set_y(mk(6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56));
    end
  endtask

  task automatic finish_frame(input logic exp_err);
    wait_idle();
    exp_cnt = exp_cnt + 8'd1;
    chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    chk("order_err_hold", {31'd0, order_err}, {31'd0, exp_err});
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0][5:0] f, input logic exp_err, input logic scramble);
    start_frame(f, exp_err, scramble);
    finish_frame(exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][5:0] fs, fu, fe;
    int acc, t;
    fs = mk(6'd1, 6'd2, 6'd4, 6'd5, 6'd7, 6'd8, 6'd45, 6'd51);
    fu = mk(6'd51, 6'd4, 6'd45, 6'd2, 6'd1, 6'd8, 6'd5, 6'd7);
    fe = mk(6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63);

    // Reset state
    #12;
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {26'd0, tx_data}, 32'd0);
    chk("rst_tx_idx", {29'd0, tx_idx}, 32'd0);
    chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
    chk("rst_order_err", {31'd0, order_err}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sorted frame
    send_frame(fs, 1'b0, 1'b0);

    // Backpressure, then backpressure with y changes and a stray load mid-frame
    bp_en = 1'b1;
    send_frame(fs, 1'b0, 1'b0);
    send_frame(fs, 1'b0, 1'b1);
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Unsorted frame, then a sorted one clears the flag at its load edge
    send_frame(fu, 1'b1, 1'b0);
    send_frame(fs, 1'b0, 1'b0);

    // Equal-valued frame
    send_frame(fe, 1'b0, 1'b0);

    // Load held high for three frames: 27 cycles
    set_y(fs);
    load = 1'b1;
    acc = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (load_ready) begin push_frame(fs); acc++; end
      @(posedge clk);
    end
    #1;
    load = 1'b0;
    exp_cnt = exp_cnt + 8'd3;
    chk("cont_loads", acc, 32'd3);
    chk("cont_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    chk("cont_idle", {31'd0, load_ready}, 32'd1);
    chk("cont_sb_drained", sb.size(), 32'd0);

    // Reset mid-frame after word 3
    start_frame(fu, 1'b1, 1'b0);
    t = 0;
    while (tx_idx != 3'd4 && t < 50) begin @(posedge clk); #1; t++; end
    if (tx_idx != 3'd4) fail_now("timeout_idx4");
    rst = 1'b1;
    #1;
    chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("abort_order_err", {31'd0, order_err}, 32'd0);
    chk("abort_tx_idx", {29'd0, tx_idx}, 32'd0);
    chk("abort_tx_data", {26'd0, tx_data}, 32'd0);
    chk("abort_load_ready", {31'd0, load_ready}, 32'd1);
    sb.delete();
    exp_cnt = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(fs, 1'b0, 1'b0);

    // Wrap: 255 more frames makes 256 since reset
    for (int n = 0; n < 255; n++) send_frame(fs, 1'b0, 1'b0);
    chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
